// File: rtl/exu_hs_stage.sv
// exu_hs_stage: execute stage between IDU and WBU with valid/ready on both
// sides and a registered result buffer. Single-cycle ALU ops stream at full
// rate; writes to x0 are dropped here by clearing out_wen.
// Optional macro EXU_HS_MUL_EN: opcode 10 runs on an iterative shift-add
// multiplier (one bit of B per cycle, XLEN cycles in BUSY). Without it,
// opcode 10 returns 0 in a single cycle and busy is tied low.
module exu_hs_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5,
  parameter int unsigned SH_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RD_W-1:0] out_rd,
  output logic            out_wen,
  output logic [XLEN-1:0] out_wdata,
  output logic            busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd2;
`ifdef EXU_HS_MUL_EN
  localparam logic [1:0] S_BUSY = 2'd1;
`endif

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_PASSB = 4'd11;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic            load_res;
  logic [XLEN-1:0] op_b;
  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] alu_res;

`ifdef EXU_HS_MUL_EN
  logic            is_mul;
  logic            mul_start;
  logic            mul_done;
  logic [XLEN-1:0] mul_a;
  logic [XLEN-1:0] mul_b;
  logic [XLEN-1:0] mul_acc;
  logic [XLEN-1:0] mul_acc_nxt;
  logic [SH_W-1:0] mul_cnt;

  assign is_mul      = (in_op == OP_MUL);
  assign mul_acc_nxt = mul_acc + (mul_b[0] ? mul_a : '0);
`endif

  assign op_b     = in_use_imm ? in_imm : in_src2;
  assign shamt    = op_b[SH_W-1:0];
  assign in_ready = (state == S_IDLE) | ((state == S_HOLD) & out_ready);

  // Single-cycle ALU result from the current input operands
  always_comb begin
    alu_res = '0;
    case (in_op)
      OP_ADD:   alu_res = in_src1 + op_b;
      OP_SUB:   alu_res = in_src1 - op_b;
      OP_AND:   alu_res = in_src1 & op_b;
      OP_OR:    alu_res = in_src1 | op_b;
      OP_XOR:   alu_res = in_src1 ^ op_b;
      OP_SLL:   alu_res = in_src1 << shamt;
      OP_SRL:   alu_res = in_src1 >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(in_src1) >>> shamt);
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(in_src1) < $signed(op_b))};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (in_src1 < op_b)};
      OP_MUL:   alu_res = '0;
      OP_PASSB: alu_res = op_b;
      default:  alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath load strobes
  always_comb begin
    state_nxt = state;
    load_res  = 1'b0;
`ifdef EXU_HS_MUL_EN
    mul_start = 1'b0;
    mul_done  = 1'b0;
`endif
    case (state)
      S_IDLE, S_HOLD: begin
        if (in_valid & in_ready) begin
`ifdef EXU_HS_MUL_EN
          if (is_mul) begin
            state_nxt = S_BUSY;
            mul_start = 1'b1;
          end else
`endif
          begin
            state_nxt = S_HOLD;
            load_res  = 1'b1;
          end
        end else if ((state == S_HOLD) & out_ready) begin
          state_nxt = S_IDLE;
        end
      end
`ifdef EXU_HS_MUL_EN
      S_BUSY: begin
        if (mul_cnt == SH_W'(XLEN - 1)) begin
          state_nxt = S_HOLD;
          mul_done  = 1'b1;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output buffer: rd/wen captured at accept, data at ALU accept or MUL finish
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_wen   <= 1'b0;
      out_rd    <= '0;
      out_wdata <= '0;
    end else begin
      out_valid <= (state_nxt == S_HOLD);
      if (in_valid & in_ready) begin
        out_rd  <= in_rd;
        out_wen <= in_wen & (in_rd != '0);
      end
      if (load_res) begin
        out_wdata <= alu_res;
      end
`ifdef EXU_HS_MUL_EN
      else if (mul_done) begin
        out_wdata <= mul_acc_nxt;
      end
`endif
    end
  end

`ifdef EXU_HS_MUL_EN
  // Busy flag mirrors the BUSY state
  always_ff @(posedge clk) begin
    if (rst) busy <= 1'b0;
    else     busy <= (state_nxt == S_BUSY);
  end

  // Shift-add multiplier: one bit of B per BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
      mul_cnt <= '0;
    end else if (mul_start) begin
      mul_a   <= in_src1;
      mul_b   <= op_b;
      mul_acc <= '0;
      mul_cnt <= '0;
    end else if (state == S_BUSY) begin
      mul_a   <= mul_a << 1;
      mul_b   <= mul_b >> 1;
      mul_acc <= mul_acc_nxt;
      mul_cnt <= mul_cnt + SH_W'(1);
    end
  end
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_exu_hs_stage.sv
// Directed bench for exu_hs_stage with a transaction-level reference model.
module tb_exu_hs_stage;

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] wdata;
    int          cyc;
  } xfer_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        ui;
    logic [4:0]  rd;
    logic        w;
  } vec_t;

`ifdef EXU_HS_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_src1, in_src2, in_imm;
  logic        in_use_imm;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [31:0] out_wdata;
  logic        busy;

  xfer_t exp_q[$];
  xfer_t log_q[$];
  vec_t  vecs[10];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;

  exu_hs_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_wen(out_wen), .out_wdata(out_wdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference: what an instruction must produce, from the opcode table
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa, sb;
    int sh;
    sa = a;
    sb = b;
    sh = int'(b % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return sa >>> sh;
      4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: begin
`ifdef EXU_HS_MUL_EN
        return a * b;
`else
        return 32'd0;
`endif
      end
      4'd11: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Present one instruction and hold it until accepted; model entry pushed at accept
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic ui, input logic [4:0] rd,
                      input logic w, output int waits);
    logic  acc;
    xfer_t e;
    in_op = op; in_src1 = a; in_src2 = b; in_imm = imm;
    in_use_imm = ui; in_rd = rd; in_wen = w; in_valid = 1'b1;
    waits = 0;
    acc = 1'b0;
    while (!acc && waits < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (!acc) begin
        waits++;
        if (waits >= 2) begin
          #1;
          out_ready = 1'b1;
        end
      end
    end
    if (acc) begin
      e.rd = rd;
      e.wen = w & (rd != 5'd0);
      e.wdata = model(op, a, ui ? imm : b);
      e.cyc = cyc;
      exp_q.push_back(e);
    end else begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
    #1;
    in_valid = 1'b0;
  endtask

  // Compare every presented result against the oldest outstanding instruction
  always @(negedge clk) begin : mon
    xfer_t t;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got rd=%0d wdata=%h expected no output", out_rd, out_wdata);
      end else begin
        chk("mdl_rd", 32'(out_rd), 32'(exp_q[0].rd));
        chk("mdl_wen", 32'(out_wen), 32'(exp_q[0].wen));
        chk("mdl_wdata", out_wdata, exp_q[0].wdata);
        if (out_ready) begin
          t.rd = out_rd; t.wen = out_wen; t.wdata = out_wdata; t.cyc = cyc;
          log_q.push_back(t);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int w0, w1, first, bn, viol, vcnt;

    vecs[0] = '{4'd2,  32'hF0F01234, 32'h0FF0FFFF, 32'h0,        1'b0, 5'd6,  1'b1};
    vecs[1] = '{4'd3,  32'hF0000000, 32'h0,        32'h0000000F, 1'b1, 5'd7,  1'b1};
    vecs[2] = '{4'd4,  32'hAAAAAAAA, 32'hFFFF0000, 32'h0,        1'b0, 5'd8,  1'b1};
    vecs[3] = '{4'd5,  32'h00000001, 32'h00000023, 32'h0,        1'b0, 5'd9,  1'b1};
    vecs[4] = '{4'd6,  32'h80000000, 32'h0,        32'd31,       1'b1, 5'd10, 1'b1};
    vecs[5] = '{4'd11, 32'hDEADBEEF, 32'h0,        32'h12345678, 1'b1, 5'd11, 1'b1};
    vecs[6] = '{4'd13, 32'h00000001, 32'h00000002, 32'h0,        1'b0, 5'd12, 1'b1};
    vecs[7] = '{4'd10, 32'h00000003, 32'h00000005, 32'h0,        1'b0, 5'd13, 1'b1};
    vecs[8] = '{4'd8,  32'h00000001, 32'hFFFFFFFF, 32'h0,        1'b0, 5'd14, 1'b1};
    vecs[9] = '{4'd0,  32'h00000010, 32'h00000020, 32'h0,        1'b0, 5'd15, 1'b0};

    // Reset with in_valid held high
    rst = 1'b1; in_valid = 1'b1; in_op = 4'd0; in_src1 = 32'h5; in_src2 = 32'h6;
    in_imm = 32'h7; in_use_imm = 1'b0; in_rd = 5'd1; in_wen = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wdata", out_wdata, 32'd0);
    chk("rst_wen", 32'(out_wen), 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Back-to-back ADD then SUB
    @(posedge clk);
    #1;
    log_q.delete();
    send(4'd0, 32'hFFFFFFFF, 32'h0, 32'd1, 1'b1, 5'd3, 1'b1, w0);
    send(4'd1, 32'd5, 32'd7, 32'h0, 1'b0, 5'd4, 1'b1, w1);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_wait0", 32'(w0), 32'd0);
    chk("b2b_wait1", 32'(w1), 32'd0);
    chk("b2b_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() >= 2) begin
      chk("b2b_data0", log_q[0].wdata, 32'h00000000);
      chk("b2b_rd0", 32'(log_q[0].rd), 32'd3);
      chk("b2b_data1", log_q[1].wdata, 32'hFFFFFFFE);
      chk("b2b_rd1", 32'(log_q[1].rd), 32'd4);
      chk("b2b_gap", 32'(log_q[1].cyc - log_q[0].cyc), 32'd1);
    end

    // Backpressure on SRA; a stray request must not be taken while held
    log_q.delete();
    out_ready = 1'b0;
    send(4'd7, 32'h80000000, 32'd4, 32'h0, 1'b0, 5'd5, 1'b1, w0);
    in_valid = 1'b1; in_op = 4'd0; in_rd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_wdata", out_wdata, 32'hF8000000);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() >= 1) chk("bp_xfer_data", log_q[0].wdata, 32'hF8000000);

    // x0 suppression, signed vs unsigned compare
    log_q.delete();
    send(4'd8, 32'hFFFFFFFF, 32'h0, 32'd1, 1'b1, 5'd0, 1'b1, w0);
    send(4'd9, 32'hFFFFFFFF, 32'h0, 32'd1, 1'b1, 5'd0, 1'b1, w0);
    repeat (3) @(posedge clk);
    #1;
    chk("cmp_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() >= 2) begin
      chk("slt_data", log_q[0].wdata, 32'd1);
      chk("slt_x0_wen", 32'(log_q[0].wen), 32'd0);
      chk("sltu_data", log_q[1].wdata, 32'd0);
    end

    // Opcode 10: iterative multiply when enabled, zero result otherwise
    log_q.delete();
    first = 0; bn = 0; viol = 0;
    send(4'd10, 32'h00010001, 32'h00010003, 32'h0, 1'b0, 5'd1, 1'b1, w0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) bn++;
      if (busy && in_ready) viol++;
      if (out_valid && first == 0) first = k;
    end
    chk("mul_first_valid", 32'(first), MUL_EN ? 32'd33 : 32'd1);
    chk("mul_busy_cycles", 32'(bn), MUL_EN ? 32'd32 : 32'd0);
    chk("mul_ready_in_busy", 32'(viol), 32'd0);
    chk("mul_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() >= 1) chk("mul_data", log_q[0].wdata, MUL_EN ? 32'h00040003 : 32'd0);

    // Mixed sweep with intermittent backpressure, checked by the model
    log_q.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      out_ready = (i % 3 != 2);
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].ui, vecs[i].rd, vecs[i].w, w0);
    end
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("sweep_drained", 32'(exp_q.size()), 32'd0);
    chk("sweep_count", 32'(log_q.size()), 32'd10);
    if (log_q.size() >= 10) begin
      chk("sll_mask", log_q[3].wdata, 32'd8);
      chk("srl_31", log_q[4].wdata, 32'd1);
      chk("passb", log_q[5].wdata, 32'h12345678);
      chk("op13_zero", log_q[6].wdata, 32'd0);
      chk("slt_pos_neg", log_q[8].wdata, 32'd0);
      chk("wen0", 32'(log_q[9].wen), 32'd0);
    end

    // Reset while an instruction is in flight
    out_ready = 1'b0;
    send(MUL_EN ? 4'd10 : 4'd0, 32'd7, 32'd9, 32'h0, 1'b0, 5'd2, 1'b1, w0);
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'(MUL_EN));
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    chk("mid_no_output", 32'(vcnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
